ddr_tx_framer: RTL and testbench



---
 rtl/ddr_tx_pkg.sv | 20 ++
 rtl/ddr_tx_fifo.sv | 49 ++++
 rtl/ddr_tx_framer.sv | 127 ++++++++++++
 tb/tb_ddr_tx_framer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tx_pkg.sv
// Shared types for the DDR transmit framer: FSM states, FIFO entry layout, default SYNC word.
package ddr_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hD5D5_5A5A;

endpackage

// File: rtl/ddr_tx_fifo.sv
// Synchronous FIFO with combinational head read; push lands next cycle, zero-latency head.
// Backpressure: full blocks push, empty blocks pop; simultaneous push/pop keeps count.
module ddr_tx_fifo
    import ddr_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       wr_dat,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    // The extra pointer bit separates full (wrapped once) from empty.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/ddr_tx_framer.sv
// Frames buffered payload as SYNC/data/XOR-checksum over 16 DDR pins; SYNC appears 1 cycle after first push.
// Backpressure: in_ready drops while the FIFO is full; FIFO underrun inserts idle gaps mid-frame.
module ddr_tx_framer
    import ddr_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    output logic        tx_oe
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        csum_q, csum_d;
    logic               vld_d;
    logic               last_q, last_d;
    logic               oe_q;
    logic [15:0]        lo_q;
    logic [15:0]        hi_q;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_rd_dat;
    fifo_entry_t        head;

    ddr_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (in_valid && in_ready),
        .wr_dat ({in_last, in_data}),
        .pop    (pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign head     = fifo_rd_dat;
    assign in_ready = !fifo_full && oe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // state_q names what word_q is currently showing; last_q marks a shown final data word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fifo_empty ? IDLE : SYNC;
            SYNC:    state_d = DATA;
            DATA:    state_d = last_q ? CSUM : DATA;
            CSUM:    state_d = fifo_empty ? IDLE : SYNC;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        word_d = '0;
        vld_d  = 1'b0;
        csum_d = csum_q;
        last_d = 1'b0;
        case (state_d)
            SYNC: begin
                word_d = SYNC_WORD;
                vld_d  = 1'b1;
                csum_d = '0;
            end
            DATA: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    word_d = head.data;
                    vld_d  = 1'b1;
                    csum_d = csum_q ^ head.data;
                    last_d = head.last;
                end
            end
            CSUM: begin
                word_d = csum_q;
                vld_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q   <= '0;
            tx_valid <= 1'b0;
            csum_q   <= '0;
            last_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            word_q   <= word_d;
            tx_valid <= vld_d;
            csum_q   <= csum_d;
            last_q   <= last_d;
            oe_q     <= 1'b1;
        end
    end

    // High half is re-timed to the falling edge so it is stable for the whole low phase.
    always_ff @(negedge clk) begin
        if (!rst_n) hi_q <= '0;
        else        hi_q <= word_q[31:16];
    end

    assign lo_q    = word_q[15:0];
    assign tx_data = clk ? lo_q : hi_q;
    assign tx_oe   = oe_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= DEPTH_CNT);

endmodule

// File: tb/tb_ddr_tx_framer.sv
// Directed bench for ddr_tx_framer: samples pins in both clock phases and compares against hand tables.
module tb_ddr_tx_framer;

    localparam logic [31:0] SW = 32'hD5D5_5A5A;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_oe;

    int errors = 0;
    int checks = 0;

    logic [15:0] s_lo, s_hi;
    logic [31:0] s_word;
    logic        s_vld, s_rdy, s_oe;

    ddr_tx_framer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_oe    (tx_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: edge, then sample the clk-high phase, then the clk-low phase.
    task automatic cyc();
        @(posedge clk);
        #2;
        s_lo  = tx_data;
        s_vld = tx_valid;
        s_rdy = in_ready;
        s_oe  = tx_oe;
        @(negedge clk);
        #2;
        s_hi   = tx_data;
        s_word = {s_hi, s_lo};
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b want 0", i, s_rdy); end
            checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b want 0", i, s_vld); end
            checks++; if (s_oe !== 1'b0) begin errors++; $display("FAIL reset_oe[%0d] got %b want 0", i, s_oe); end
            checks++; if (s_lo !== 16'h0) begin errors++; $display("FAIL reset_lo[%0d] got %h want 0000", i, s_lo); end
            checks++; if (s_hi !== 16'h0) begin errors++; $display("FAIL reset_hi[%0d] got %h want 0000", i, s_hi); end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc();
        checks++; if (s_oe !== 1'b1) begin errors++; $display("FAIL post_reset_oe got %b want 1", s_oe); end
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", s_rdy); end
        checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", s_vld); end
    endtask

    task automatic test_single_word();
        logic [31:0] ew [6];
        logic        ev [6];
        ew = '{32'h0, SW, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            in_valid = (k == 0);
            in_last  = 1'b1;
            in_data  = 32'h1234_5678;
            cyc();
            checks++; if (s_word !== ew[k]) begin errors++; $display("FAIL single_word[%0d] got %h want %h", k, s_word, ew[k]); end
            checks++; if (s_vld !== ev[k]) begin errors++; $display("FAIL single_valid[%0d] got %b want %b", k, s_vld, ev[k]); end
        end
    endtask

    task automatic test_three_word();
        logic [31:0] wd [3];
        logic [31:0] ew [8];
        logic        ev [8];
        wd = '{32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000};
        ew = '{32'h0, SW, 32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'h00FF_FFFF, 32'h0, 32'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 3);
            in_last  = (k == 2);
            in_data  = (k < 3) ? wd[k] : 32'h0;
            cyc();
            checks++; if (s_word !== ew[k]) begin errors++; $display("FAIL three_word[%0d] got %h want %h", k, s_word, ew[k]); end
            checks++; if (s_vld !== ev[k]) begin errors++; $display("FAIL three_valid[%0d] got %b want %b", k, s_vld, ev[k]); end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] ew [8];
        logic        ev [8];
        ew = '{32'h0, SW, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0F0F_1234, 32'hC5F1_1235, 32'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            in_valid = (k == 0) || (k == 4);
            in_last  = (k == 4);
            in_data  = (k == 0) ? 32'hCAFE_0001 : 32'h0F0F_1234;
            cyc();
            checks++; if (s_word !== ew[k]) begin errors++; $display("FAIL underrun_word[%0d] got %h want %h", k, s_word, ew[k]); end
            checks++; if (s_vld !== ev[k]) begin errors++; $display("FAIL underrun_valid[%0d] got %b want %b", k, s_vld, ev[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [3];
        logic [31:0] ew [9];
        logic        ev [9];
        wd = '{32'h1111_0000, 32'h0000_2222, 32'h3333_4444};
        ew = '{32'h0, SW, 32'h1111_0000, 32'h0000_2222, 32'h1111_2222, SW, 32'h3333_4444, 32'h3333_4444, 32'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) begin
            in_valid = (k < 3);
            in_last  = (k == 1) || (k == 2);
            in_data  = (k < 3) ? wd[k] : 32'h0;
            cyc();
            checks++; if (s_word !== ew[k]) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", k, s_word, ew[k]); end
            checks++; if (s_vld !== ev[k]) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", k, s_vld, ev[k]); end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [31:0] ew [10];
        logic        ev [10];
        logic        eo [10];
        ew = '{32'h0, SW, 32'hAAAA_0001, 32'h0, 32'h0, 32'h0, SW, 32'h7777_8888, 32'h7777_8888, 32'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        eo = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 10; k++) begin
            rst_n    = (k != 3);
            in_valid = (k == 0) || (k == 1) || (k == 5);
            in_last  = (k == 5);
            in_data  = (k == 0) ? 32'hAAAA_0001 : (k == 1) ? 32'hBBBB_0002 : 32'h7777_8888;
            cyc();
            checks++; if (s_word !== ew[k]) begin errors++; $display("FAIL rst_word[%0d] got %h want %h", k, s_word, ew[k]); end
            checks++; if (s_vld !== ev[k]) begin errors++; $display("FAIL rst_valid[%0d] got %b want %b", k, s_vld, ev[k]); end
            checks++; if (s_oe !== eo[k]) begin errors++; $display("FAIL rst_oe[%0d] got %b want %b", k, s_oe, eo[k]); end
        end
        rst_n = 1'b1;
    endtask

    // Single-word frames carry two non-popping cycles each, so a steady producer fills the FIFO.
    task automatic test_backpressure();
        logic [31:0] wd [6];
        logic [31:0] got [$];
        logic [31:0] exp_w;
        int          n_acc;
        int          acc_at_low;
        logic        rdy_before;
        logic        pushing;
        for (int i = 0; i < 6; i++) wd[i] = 32'hA5A5_0000 + i;
        n_acc      = 0;
        acc_at_low = -1;
        rdy_before = 1'b1;
        for (int c = 0; c < 200 && got.size() < 18; c++) begin
            pushing  = (n_acc < 6);
            in_valid = pushing;
            in_last  = 1'b1;
            in_data  = pushing ? wd[n_acc] : 32'h0;
            cyc();
            if (pushing && rdy_before) n_acc++;
            if (!s_rdy && acc_at_low < 0) acc_at_low = n_acc;
            rdy_before = s_rdy;
            if (s_vld) got.push_back(s_word);
        end
        in_valid = 1'b0;
        checks++; if (acc_at_low !== 5) begin errors++; $display("FAIL bp_ready_drop accepted=%0d want 5", acc_at_low); end
        checks++; if (n_acc !== 6) begin errors++; $display("FAIL bp_accepted got %0d want 6", n_acc); end
        checks++; if (got.size() !== 18) begin errors++; $display("FAIL bp_out_count got %0d want 18", got.size()); end
        for (int j = 0; j < 18 && j < got.size(); j++) begin
            exp_w = (j % 3 == 0) ? SW : wd[j / 3];
            checks++; if (got[j] !== exp_w) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", j, got[j], exp_w); end
        end
        for (int k = 0; k < 3; k++) cyc();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
        test_reset();
        test_single_word();
        test_three_word();
        test_underrun();
        test_back_to_back();
        test_backpressure();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
